// File: rtl/vx_dmem_lane_arbiter.sv
// ============================================================================
// Module      : vx_dmem_lane_arbiter
// Description : Round-robin TileLink-UL A-channel arbiter across dmem lanes,
//               with D-channel demux, per-lane outstanding throttling and a
//               sticky protocol-error flag. Optional performance counters are
//               enabled by defining VX_DMEM_LANE_ARB_PERF_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module vx_dmem_lane_arbiter #(
    parameter int NUM_LANES       = 4,
    parameter int SRC_W           = 10,
    parameter int MAX_OUTSTANDING = 8
) (
    input  logic                                  clock,
    input  logic                                  reset_n,
    input  logic [NUM_LANES-1:0]                  in_a_valid,
    output logic [NUM_LANES-1:0]                  in_a_ready,
    input  logic [NUM_LANES*3-1:0]                in_a_opcode,
    input  logic [NUM_LANES*4-1:0]                in_a_size,
    input  logic [NUM_LANES*SRC_W-1:0]            in_a_source,
    input  logic [NUM_LANES*32-1:0]               in_a_address,
    input  logic [NUM_LANES*4-1:0]                in_a_mask,
    input  logic [NUM_LANES*32-1:0]               in_a_data,
    output logic [NUM_LANES-1:0]                  in_d_valid,
    input  logic [NUM_LANES-1:0]                  in_d_ready,
    output logic [2:0]                            in_d_opcode,
    output logic [3:0]                            in_d_size,
    output logic [SRC_W-1:0]                      in_d_source,
    output logic [31:0]                           in_d_data,
    output logic                                  out_a_valid,
    input  logic                                  out_a_ready,
    output logic [2:0]                            out_a_opcode,
    output logic [3:0]                            out_a_size,
    output logic [SRC_W+$clog2(NUM_LANES)-1:0]    out_a_source,
    output logic [31:0]                           out_a_address,
    output logic [3:0]                            out_a_mask,
    output logic [31:0]                           out_a_data,
    input  logic                                  out_d_valid,
    output logic                                  out_d_ready,
    input  logic [2:0]                            out_d_opcode,
    input  logic [3:0]                            out_d_size,
    input  logic [SRC_W+$clog2(NUM_LANES)-1:0]    out_d_source,
    input  logic [31:0]                           out_d_data,
    output logic                                  busy,
    output logic                                  err
`ifdef VX_DMEM_LANE_ARB_PERF_EN
    ,
    output logic [NUM_LANES*32-1:0]               perf_grant_cnt,
    output logic [31:0]                           perf_stall_cnt
`endif
);

    localparam int LANE_W = $clog2(NUM_LANES);
    localparam int CNT_W  = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [CNT_W-1:0] C_CNT_MAX = CNT_W'(MAX_OUTSTANDING);

    logic [LANE_W-1:0]   r_rr_ptr;
    logic [LANE_W-1:0]   r_locked_lane;
    logic                r_lock;
    logic                r_err;
    logic [CNT_W-1:0]    r_cnt [NUM_LANES];

    logic [NUM_LANES-1:0] w_elig;
    logic [LANE_W-1:0]   w_grant;
    logic [LANE_W-1:0]   w_idx;
    logic                w_found;
    logic                w_a_fire;
    logic                w_lock_drop;
    logic [LANE_W-1:0]   w_d_lane;
    logic                w_d_in_range;
    logic                w_d_sel_ready;
    logic                w_d_cnt_zero;
    logic                w_d_fire;
    logic [SRC_W-1:0]    w_a_src;

    always_comb begin
        for (int i = 0; i < NUM_LANES; i++) begin
            w_elig[i] = in_a_valid[i] && (r_cnt[i] != C_CNT_MAX);
        end
    end

    // A locked lane keeps the grant so a stalled beat cannot change under the slave.
    always_comb begin
        w_grant = r_rr_ptr;
        w_idx   = '0;
        w_found = 1'b0;
        if (r_lock) begin
            w_grant = r_locked_lane;
        end else begin
            for (int k = 0; k < NUM_LANES; k++) begin
                w_idx = LANE_W'((int'(r_rr_ptr) + k) % NUM_LANES);
                if (!w_found && w_elig[w_idx]) begin
                    w_found = 1'b1;
                    w_grant = w_idx;
                end
            end
        end
    end

    assign w_lock_drop = r_lock && !in_a_valid[r_locked_lane];
    assign out_a_valid = r_lock ? in_a_valid[r_locked_lane] : (|w_elig);
    assign w_a_fire    = out_a_valid && out_a_ready;

    always_comb begin
        out_a_opcode  = in_a_opcode[2:0];
        out_a_size    = in_a_size[3:0];
        w_a_src       = in_a_source[SRC_W-1:0];
        out_a_address = in_a_address[31:0];
        out_a_mask    = in_a_mask[3:0];
        out_a_data    = in_a_data[31:0];
        for (int i = 0; i < NUM_LANES; i++) begin
            if (w_grant == LANE_W'(i)) begin
                out_a_opcode  = in_a_opcode[i*3 +: 3];
                out_a_size    = in_a_size[i*4 +: 4];
                w_a_src       = in_a_source[i*SRC_W +: SRC_W];
                out_a_address = in_a_address[i*32 +: 32];
                out_a_mask    = in_a_mask[i*4 +: 4];
                out_a_data    = in_a_data[i*32 +: 32];
            end
        end
    end
    assign out_a_source = {w_grant, w_a_src};

    // D channel: the upper source bits carry the lane index prepended on A.
    assign w_d_lane    = out_d_source[SRC_W +: LANE_W];
    assign in_d_opcode = out_d_opcode;
    assign in_d_size   = out_d_size;
    assign in_d_source = out_d_source[SRC_W-1:0];
    assign in_d_data   = out_d_data;

    generate
        if ((1 << LANE_W) == NUM_LANES) begin : g_d_range_pow2
            assign w_d_in_range = 1'b1;
        end else begin : g_d_range_check
            assign w_d_in_range = ({{(32-LANE_W){1'b0}}, w_d_lane} < 32'(NUM_LANES));
        end
    endgenerate

    always_comb begin
        w_d_sel_ready = 1'b0;
        w_d_cnt_zero  = 1'b0;
        for (int i = 0; i < NUM_LANES; i++) begin
            if (w_d_lane == LANE_W'(i)) begin
                w_d_sel_ready = in_d_ready[i];
                w_d_cnt_zero  = (r_cnt[i] == '0);
            end
        end
    end

    // Out-of-range beats are accepted and dropped so the D channel never wedges.
    assign out_d_ready = w_d_in_range ? w_d_sel_ready : 1'b1;
    assign w_d_fire    = out_d_valid && out_d_ready && w_d_in_range;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_rr_ptr      <= '0;
            r_lock        <= 1'b0;
            r_locked_lane <= '0;
            r_err         <= 1'b0;
        end else begin
            if (w_a_fire) begin
                r_rr_ptr <= LANE_W'((int'(w_grant) + 1) % NUM_LANES);
                r_lock   <= 1'b0;
            end else if (w_lock_drop) begin
                r_lock   <= 1'b0;
            end else if (out_a_valid && !out_a_ready) begin
                r_lock        <= 1'b1;
                r_locked_lane <= w_grant;
            end
            if (w_lock_drop || (out_d_valid && !w_d_in_range) || (w_d_fire && w_d_cnt_zero)) begin
                r_err <= 1'b1;
            end
        end
    end

    generate
        for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
            logic w_inc;
            logic w_dec;
            assign w_inc         = w_a_fire && (w_grant == LANE_W'(g));
            assign w_dec         = w_d_fire && (w_d_lane == LANE_W'(g));
            assign in_a_ready[g] = w_inc;
            assign in_d_valid[g] = out_d_valid && w_d_in_range && (w_d_lane == LANE_W'(g));

            always_ff @(posedge clock) begin
                if (!reset_n) begin
                    r_cnt[g] <= '0;
                end else if (w_inc && !w_dec) begin
                    r_cnt[g] <= r_cnt[g] + 1'b1;
                end else if (w_dec && !w_inc && (r_cnt[g] != '0)) begin
                    r_cnt[g] <= r_cnt[g] - 1'b1;
                end
            end

`ifdef VX_DMEM_LANE_ARB_PERF_EN
            logic [31:0] r_perf_grant;
            always_ff @(posedge clock) begin
                if (!reset_n) begin
                    r_perf_grant <= '0;
                end else if (w_inc) begin
                    r_perf_grant <= r_perf_grant + 32'd1;
                end
            end
            assign perf_grant_cnt[g*32 +: 32] = r_perf_grant;
`endif
        end
    endgenerate

`ifdef VX_DMEM_LANE_ARB_PERF_EN
    logic [31:0] r_perf_stall;
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_perf_stall <= '0;
        end else if (out_a_valid && !out_a_ready) begin
            r_perf_stall <= r_perf_stall + 32'd1;
        end
    end
    assign perf_stall_cnt = r_perf_stall;
`endif

    always_comb begin
        busy = 1'b0;
        for (int i = 0; i < NUM_LANES; i++) begin
            if (r_cnt[i] != '0) begin
                busy = 1'b1;
            end
        end
    end
    assign err = r_err;

endmodule

`default_nettype wire

// File: doc/vx_dmem_lane_arbiter.md
Name: vx_dmem_lane_arbiter

Overview:
- Shares one TileLink-UL master port between the NUM_LANES per-thread dmem lanes that the Vortex tile adapter drives.
- A channel: round-robin arbitration. The lane index is prepended to the source ID.
- D channel: demuxed back to the originating lane by the upper source bits.
- Tracks outstanding requests per lane, throttles at MAX_OUTSTANDING, and reports busy/error to the tile.

Parameters:
- NUM_LANES, 4, number of lane-side A/D channel pairs (≥2).
- SRC_W, 10, lane-side source ID width.
- MAX_OUTSTANDING, 8, per-lane in-flight request limit (≥1).
- LANE_W, $clog2(NUM_LANES), lane index width (derived, not overridable).

Ports:
- clock in 1: clock.
- reset_n in 1: synchronous active-low reset.
- in_a_valid in NUM_LANES: per-lane A valid.
- in_a_ready out NUM_LANES: per-lane A ready.
- in_a_opcode in NUM_LANES*3, in_a_size in NUM_LANES*4, in_a_source in NUM_LANES*SRC_W, in_a_address in NUM_LANES*32, in_a_mask in NUM_LANES*4, in_a_data in NUM_LANES*32: packed lane A fields, lane 0 in the LSBs.
- in_d_valid out NUM_LANES: per-lane D valid.
- in_d_ready in NUM_LANES: per-lane D ready.
- in_d_opcode out 3, in_d_size out 4, in_d_source out SRC_W, in_d_data out 32: D fields broadcast to all lanes.
- out_a_valid out 1, out_a_ready in 1, out_a_opcode out 3, out_a_size out 4, out_a_source out SRC_W+LANE_W, out_a_address out 32, out_a_mask out 4, out_a_data out 32: downstream A channel.
- out_d_valid in 1, out_d_ready out 1, out_d_opcode in 3, out_d_size in 4, out_d_source in SRC_W+LANE_W, out_d_data in 32: downstream D channel.
- busy out 1: any lane has a request outstanding.
- err out 1: sticky protocol error.

Behaviour:
- Clocking and reset: one clock, `clock`; reset `reset_n` is synchronous, active-low.
- Reset state: rr_ptr=0, lock=0, locked_lane=0, all outstanding counters=0, err=0. Hence out_a_valid=0, busy=0, err=0, in_d_valid=0 (while out_d_valid=0).
- Lane eligibility: lane i is eligible iff in_a_valid[i] && cnt[i] != MAX_OUTSTANDING.
- Grant, unlocked case: the first eligible lane searching rr_ptr, rr_ptr+1, … mod NUM_LANES. Combinational, zero-cycle A latency.
- Output A fields: out_a_valid = any eligible. Fields are muxed from the granted lane. out_a_source = {grant[LANE_W-1:0], lane source}.
- Lane A ready: in_a_ready[i] = out_a_ready && out_a_valid && grant==i.
- Lock: out_a_valid && !out_a_ready at a clock edge sets lock=1 and locked_lane=grant.
  - While locked, grant=locked_lane regardless of other lanes, so A stays stable as TileLink requires.
  - The lock is not released by counter saturation; the held beat is already counted as pending only on fire.
  - Lock clears on fire.
- Lane deasserting in_a_valid while locked is a protocol error: set err, clear lock, do not issue.
- Pointer update: on A fire, rr_ptr <= (grant+1) mod NUM_LANES. rr_ptr is otherwise unchanged.
- Counters, width $clog2(MAX_OUTSTANDING+1):
  - +1 on A fire for lane g.
  - −1 on D fire (out_d_valid && out_d_ready) for lane d.
  - Same lane both in one cycle: unchanged.
- D routing:
  - d = out_d_source[SRC_W +: LANE_W].
  - in_d_valid[d] = out_d_valid; all other lanes 0.
  - in_d_source = out_d_source[SRC_W-1:0].
  - out_d_ready = in_d_ready[d]. D path is zero latency.
- D error cases:
  - d ≥ NUM_LANES (non-power-of-two configs): out_d_ready=1, beat dropped, err set.
  - D fire with cnt[d]==0: counter stays 0 (no wrap), err set.
- busy = OR of all counters nonzero, registered view.
- Reset mid-transaction: all state is cleared. Late D beats for pre-reset requests are routed as normal but raise err through the underflow rule.
- err clears only on reset.

Optional Feature:
- Macro VX_DMEM_LANE_ARB_PERF_EN.
- Defined: adds output perf_grant_cnt (NUM_LANES*32, per-lane A fire count) and output perf_stall_cnt (32, cycles with out_a_valid && !out_a_ready). Both counters wrap, and both reset to 0.
- Undefined: these ports and their counters do not exist; all other behaviour is identical.

Test Plan:
- Round-robin order:
  - Stimulus: lanes 0–3 valid every cycle, out_a_ready=1, source=0x005 each.
  - Required: fires in order lane 0,1,2,3,0; out_a_source = 0x005, 0x405, 0x805, 0xC05; busy=1 from cycle 1.
- Backpressure lock:
  - Stimulus: lane 2 granted, out_a_ready=0 for 3 cycles, lane 0 then asserts valid.
  - Required: out_a_address and out_a_source held at lane 2's values for all 3 cycles. Lane 2 fires on the 4th cycle, then lane 3 is preferred over lane 0.
- Outstanding throttle:
  - Stimulus: MAX_OUTSTANDING=2, lane 1 issues 3 requests, no D.
  - Required: only 2 fire; in_a_ready[1]=0 thereafter. One D with source 0x400|tag reopens lane 1 and cnt[1] returns to 2 after the 3rd fire.
- D demux:
  - Stimulus: out_d_source=0xC07, out_d_valid=1, in_d_ready[3]=0 for 1 cycle.
  - Required: in_d_valid=4'b1000, in_d_source=0x007, out_d_ready=0 then 1.
  - Simultaneous check: a lane-3 A fire in the same cycle as its D fire leaves cnt[3] unchanged.
- Error and reset:
  - Stimulus: D beat for lane 0 with cnt[0]=0.
  - Required: err=1 next cycle, cnt[0]=0. reset_n=0 for one edge clears err, busy, rr_ptr and any active lock.
